// File: rtl/score_bitmap_writer.sv
`default_nettype none
// ============================================================================
// Module      : score_bitmap_writer
// Description : Converts a binary score to four BCD digits and writes the
//               13-row x 44-pixel (3 bpp) score image into the score bitmap
//               RAM write port, only while vertical blanking is active.
// Revision    : 1.0 - initial release
// ============================================================================
module score_bitmap_writer #(
    parameter logic [2:0] FG_RGB = 3'b111,
    parameter logic [2:0] BG_RGB = 3'b000
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic [13:0]  score,
    input  logic         update,
    input  logic         vblank,
    output logic         busy,
    output logic         done,
    output logic         wea,
    output logic [3:0]   addra,
    output logic [131:0] dina
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONVERT  = 3'd1,
        S_WAIT_VBL = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [13:0] c_MAX_SCORE  = 14'd9999;
    localparam logic [3:0]  c_LAST_SHIFT = 4'd13;
    // Row counter value once rows 0..12 have all been issued
    localparam logic [3:0]  c_ROWS_DONE  = 4'd13;

    state_t         r_state;
    state_t         w_state_next;

    logic [13:0]    r_bin;
    logic [15:0]    r_bcd;
    logic [15:0]    w_bcd_adj;
    logic [3:0]     r_cnt;
    logic [3:0]     r_row;
    logic           r_pending;
    logic           r_wea;
    logic [3:0]     r_addra;
    logic [131:0]   r_dina;
    logic [131:0]   w_row_data;

    logic           w_load;
    logic           w_shift;
    logic           w_issue;
    logic           w_pause;
    logic           w_pend_set;
    logic           w_pend_clr;
    logic           w_busy;
    logic           w_done;

    // 8x12 glyph ROM, bit 7 is the leftmost pixel; rows beyond 11 are blank
    function automatic logic [7:0] font_row(input logic [3:0] digit, input logic [3:0] row);
        logic [95:0] glyph;
        logic [95:0] shifted;
        case (digit)
            4'd0:    glyph = 96'h003C66666E76666666663C00;
            4'd1:    glyph = 96'h001838781818181818187E00;
            4'd2:    glyph = 96'h003C6606060C183060607E00;
            4'd3:    glyph = 96'h003C6606061C060606663C00;
            4'd4:    glyph = 96'h000C1C3C6CCCFE0C0C0C0C00;
            4'd5:    glyph = 96'h007E60607C0606060666_3C00;
            4'd6:    glyph = 96'h003C6660607C666666663C00;
            4'd7:    glyph = 96'h007E06060C0C181830303000;
            4'd8:    glyph = 96'h003C6666663C666666663C00;
            4'd9:    glyph = 96'h003C666666663E0606663C00;
            default: glyph = 96'h0;
        endcase
        shifted = glyph << {row, 3'b000};
        font_row = (row <= 4'd11) ? shifted[95:88] : 8'h00;
    endfunction

    // One full display row: thousands digit leftmost, 3-pixel gap after each glyph
    function automatic logic [131:0] compose_row(input logic [15:0] bcd, input logic [3:0] row);
        logic [131:0] line;
        logic [7:0]   glyph;
        line = '0;
        for (int d = 0; d < 4; d++) begin
            glyph = font_row(bcd[4*(3-d) +: 4], row);
            for (int k = 0; k < 11; k++) begin
                line[3*(11*d+k) +: 3] = BG_RGB;
            end
            for (int k = 0; k < 8; k++) begin
                if (glyph[7-k]) begin
                    line[3*(11*d+k) +: 3] = FG_RGB;
                end
            end
        end
        return line;
    endfunction

    assign w_row_data = compose_row(r_bcd, r_row);

    // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_issue      = 1'b0;
        w_pause      = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (update) begin
                    w_load       = 1'b1;
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_busy     = 1'b1;
                w_shift    = 1'b1;
                w_pend_set = update;
                if (r_cnt == c_LAST_SHIFT) begin
                    w_state_next = S_WAIT_VBL;
                end
            end
            S_WAIT_VBL: begin
                w_busy     = 1'b1;
                w_pend_set = update;
                if (vblank) begin
                    w_issue      = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_busy     = 1'b1;
                w_pend_set = update;
                if (r_row == c_ROWS_DONE) begin
                    w_state_next = S_DONE;
                end else if (vblank) begin
                    w_issue = 1'b1;
                end else begin
                    w_pause = 1'b1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                // An update in this very cycle counts as pending too
                if (r_pending || update) begin
                    w_load       = 1'b1;
                    w_pend_clr   = 1'b1;
                    w_state_next = S_CONVERT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Score latch, BCD conversion, row sequencing and registered RAM port
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_pending <= 1'b0;
            r_wea     <= 1'b0;
            r_addra   <= '0;
            r_dina    <= '0;
        end else begin
            if (w_load) begin
                r_bin <= (score > c_MAX_SCORE) ? c_MAX_SCORE : score;
                r_bcd <= '0;
                r_cnt <= '0;
                r_row <= '0;
            end else if (w_shift) begin
                r_bcd <= {w_bcd_adj[14:0], r_bin[13]};
                r_bin <= {r_bin[12:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_pend_clr) begin
                r_pending <= 1'b0;
            end else if (w_pend_set) begin
                r_pending <= 1'b1;
            end

            if (w_issue) begin
                r_wea   <= 1'b1;
                r_addra <= r_row;
                r_dina  <= w_row_data;
                r_row   <= r_row + 4'd1;
            end else begin
                r_wea <= 1'b0;
                // While paused, point the address at the row that resumes next
                if (w_pause) begin
                    r_addra <= r_row;
                end
            end
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign wea   = r_wea;
    assign addra = r_addra;
    assign dina  = r_dina;

endmodule
`default_nettype wire
